read_bus_arbiter: RTL

Shares one memory read port between the CPU instruction-read channels (ir_addr/ir_data) and the data-read channels (dr_addr/dr_data). All channels are valid/ready.
- Address requests: round-robin arbitration, locked for the duration of a handshake.
- Issued grants: recorded in an in-order tag FIFO so that memory responses route back to the correct requester.
- Placement: between the copperv core and the memory model/bus fabric.

---
 rtl/read_bus_arbiter_pkg.sv | 15 +
 rtl/read_bus_arbiter_if.sv | 48 ++++
 rtl/read_bus_arbiter_arb_tag_fifo.sv | 56 +++++
 rtl/read_bus_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/read_bus_arbiter_pkg.sv
// Shared tag encoding for the read arbiter and its in-order response tag FIFO.
package read_bus_arbiter_pkg;

  localparam int ARB_TAG_WIDTH = 1;

  typedef logic [ARB_TAG_WIDTH-1:0] arb_tag_t;

  localparam arb_tag_t ARB_TAG_INST = 1'b0;
  localparam arb_tag_t ARB_TAG_DATA = 1'b1;

  function automatic arb_tag_t arb_other_tag(input arb_tag_t tag);
    return (tag == ARB_TAG_INST) ? ARB_TAG_DATA : ARB_TAG_INST;
  endfunction

endpackage

// File: rtl/read_bus_arbiter_if.sv
// Read-bus bundle: instruction and data read channels on the core side, one read port on the memory side.
interface read_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              ir_addr_valid;
  logic              ir_addr_ready;
  logic [ADDR_W-1:0] ir_addr;
  logic              ir_data_valid;
  logic              ir_data_ready;
  logic [DATA_W-1:0] ir_data;

  logic              dr_addr_valid;
  logic              dr_addr_ready;
  logic [ADDR_W-1:0] dr_addr;
  logic              dr_data_valid;
  logic              dr_data_ready;
  logic [DATA_W-1:0] dr_data;

  logic              mr_addr_valid;
  logic              mr_addr_ready;
  logic [ADDR_W-1:0] mr_addr;
  logic              mr_data_valid;
  logic              mr_data_ready;
  logic [DATA_W-1:0] mr_data;

  // Arbiter side.
  modport slave (
    input  ir_addr_valid, ir_addr, ir_data_ready,
    input  dr_addr_valid, dr_addr, dr_data_ready,
    input  mr_addr_ready, mr_data_valid, mr_data,
    output ir_addr_ready, ir_data_valid, ir_data,
    output dr_addr_ready, dr_data_valid, dr_data,
    output mr_addr_valid, mr_addr, mr_data_ready
  );

  // Core + memory side.
  modport master (
    output ir_addr_valid, ir_addr, ir_data_ready,
    output dr_addr_valid, dr_addr, dr_data_ready,
    output mr_addr_ready, mr_data_valid, mr_data,
    input  ir_addr_ready, ir_data_valid, ir_data,
    input  dr_addr_ready, dr_data_valid, dr_data,
    input  mr_addr_valid, mr_addr, mr_data_ready
  );

endinterface

// File: rtl/read_bus_arbiter_arb_tag_fifo.sv
// In-order tag FIFO remembering which requester owns each issued read.
// Registered head/full/empty/count; push ignored when full, pop ignored when empty.
module arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_push_dat,
  input  logic                         i_pop,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [WIDTH-1:0]             o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rptr];
  assign o_count   = r_count;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop_ok) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/read_bus_arbiter.sv
// Round-robin arbiter sharing one memory read port between instruction and data reads.
// Address grant is locked until handshake; responses route back in issue order via a tag FIFO.
module read_bus_arbiter
  import read_bus_arbiter_pkg::*;
#(
  parameter int addr_width      = 32,
  parameter int data_width      = 32,
  parameter int max_outstanding = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  read_bus_arbiter_if.slave                      bus,
  output logic [$clog2(max_outstanding+1)-1:0]   outstanding,
  output logic                                   protocol_error
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic            r_en;
  logic [0:0]      r_state;
  arb_tag_t        r_grant;
  arb_tag_t        r_rr;
  logic            r_perr;

  arb_tag_t        w_win;
  logic            w_addr_vld;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  arb_tag_t        w_head;
  logic            w_dat_rdy;
  logic [addr_width-1:0] w_mr_addr;
  logic [data_width-1:0] w_rd_data;

  // Outputs stay quiet for one full cycle after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_en <= 1'b0;
    else        r_en <= 1'b1;
  end

  always_comb begin
    w_win      = r_grant;
    w_addr_vld = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_addr_vld = r_en;
    end else if (r_en && !w_full && (bus.ir_addr_valid || bus.dr_addr_valid)) begin
      w_addr_vld = 1'b1;
      if (bus.ir_addr_valid && bus.dr_addr_valid) w_win = r_rr;
      else w_win = bus.dr_addr_valid ? ARB_TAG_DATA : ARB_TAG_INST;
    end
  end

  assign w_push            = w_addr_vld && bus.mr_addr_ready;
  assign w_mr_addr         = (w_win == ARB_TAG_DATA) ? bus.dr_addr : bus.ir_addr;
  assign bus.mr_addr_valid = w_addr_vld;
  assign bus.mr_addr       = w_mr_addr;
  assign bus.ir_addr_ready = w_push && (w_win == ARB_TAG_INST);
  assign bus.dr_addr_ready = w_push && (w_win == ARB_TAG_DATA);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_grant <= ARB_TAG_INST;
      r_rr    <= ARB_TAG_INST;
    end else if (w_push) begin
      r_state <= ST_IDLE;
      r_rr    <= arb_other_tag(w_win);
    end else if (r_state == ST_IDLE && w_addr_vld) begin
      r_state <= ST_LOCKED;
      r_grant <= w_win;
    end
  end

  // With no read outstanding, stray data is drained and flagged.
  assign w_dat_rdy = w_empty ? 1'b1 :
                     (w_head == ARB_TAG_INST) ? bus.ir_data_ready : bus.dr_data_ready;
  assign w_rd_data          = bus.mr_data;
  assign bus.mr_data_ready  = r_en && w_dat_rdy;
  assign bus.ir_data_valid  = r_en && !w_empty && (w_head == ARB_TAG_INST) && bus.mr_data_valid;
  assign bus.dr_data_valid  = r_en && !w_empty && (w_head == ARB_TAG_DATA) && bus.mr_data_valid;
  assign bus.ir_data        = w_rd_data;
  assign bus.dr_data        = w_rd_data;
  assign w_pop              = bus.mr_data_valid && bus.mr_data_ready && !w_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_perr <= 1'b0;
    else if (bus.mr_data_valid && bus.mr_data_ready && w_empty) r_perr <= 1'b1;
  end

  assign protocol_error = r_perr;

  arb_tag_fifo #(
    .DEPTH (max_outstanding),
    .WIDTH (ARB_TAG_WIDTH)
  ) u_tag_fifo (
    .clk        (clock),
    .rst_n      (reset),
    .i_push     (w_push),
    .i_push_dat (w_win),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head),
    .o_count    (outstanding)
  );

endmodule
